// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, round functions and core FSM types
package sha256_pkg;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FINAL, S_DONE} state_t;

  // Packed with a in the MSBs so the struct lines up with H0 at [255:224]
  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } sha_state_t;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = x[32*j +: 32] + y[32*j +: 32];
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round
module sha256_round
  import sha256_pkg::*;
(
  input  sha_state_t  state_in,
  input  logic [31:0] w,
  input  logic [31:0] k,
  output sha_state_t  state_out
);

  logic [31:0] t1, t2;

  always_comb begin
    t1 = state_in.h + big_sigma1(state_in.e) + ch(state_in.e, state_in.f, state_in.g) + k + w;
    t2 = big_sigma0(state_in.a) + maj(state_in.a, state_in.b, state_in.c);
    state_out.a = t1 + t2;
    state_out.b = state_in.a;
    state_out.c = state_in.b;
    state_out.d = state_in.c;
    state_out.e = state_in.d + t1;
    state_out.f = state_in.e;
    state_out.g = state_in.f;
    state_out.h = state_in.g;
  end

endmodule

// File: rtl/sha256_unrolled_core.sv
// rtl/sha256_unrolled_core.sv - SHA-256 compression core, RPC rounds per clock
module sha256_unrolled_core
  import sha256_pkg::*;
#(
  parameter int RPC      = 1,
  parameter bit FEED_FWD = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block_in,
  input  logic [255:0] digest_in,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest_out,
  output logic         busy
);

  localparam int NCYC = 64 / RPC;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
    $error("sha256_unrolled_core: RPC must be 1, 2, 4 or 8");
  end

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [31:0]       win_q [16];
  sha_state_t        hin_q, st_q, st_nxt;
  logic [255:0]      dout_q;
  logic              ov_q, ir_q, busy_q;
  logic [31:0]       ext [16+RPC];

  // Window extended by RPC words; ext[i] is W for sub-round i this cycle
  always_comb begin
    for (int k = 0; k < 16; k++) ext[k] = win_q[k];
    for (int j = 0; j < RPC; j++)
      ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
  end

  for (genvar i = 0; i < RPC; i++) begin : g_rnd
    sha_state_t si, so;
    logic [5:0] kidx;
    if (i == 0) begin : g_first
      assign si = st_q;
    end else begin : g_chain
      assign si = g_rnd[i-1].so;
    end
    assign kidx = 6'(int'(cnt_q) * RPC + i);
    sha256_round u_round (.state_in(si), .w(ext[i]), .k(K[kidx]), .state_out(so));
  end

  assign st_nxt = g_rnd[RPC-1].so;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      for (int k = 0; k < 16; k++) win_q[k] <= '0;
      hin_q   <= '0;
      st_q    <= '0;
      dout_q  <= '0;
      ov_q    <= 1'b0;
      ir_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else if (abort) begin
      state_q <= S_IDLE;
      ov_q    <= 1'b0;
      ir_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          for (int k = 0; k < 16; k++) win_q[k] <= block_in[511-32*k -: 32];
          hin_q   <= digest_in;
          ir_q    <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          st_q    <= hin_q;
          cnt_q   <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          st_q <= st_nxt;
          for (int k = 0; k < 16; k++) win_q[k] <= ext[k+RPC];
          // Counter parks on its last value; only LOAD restarts it
          if (cnt_q == CW'(NCYC - 1)) state_q <= S_FINAL;
          else                        cnt_q   <= cnt_q + 1'b1;
        end
        S_FINAL: begin
          dout_q  <= FEED_FWD ? add_words(st_q, hin_q) : st_q;
          ov_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          ov_q    <= 1'b0;
          ir_q    <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = ir_q;
  assign out_valid  = ov_q;
  assign digest_out = dout_q;
  assign busy       = busy_q;

endmodule

// File: doc/sha256_unrolled_core.md
SHA256_UNROLLED_CORE -- requirements
Module: sha256_unrolled_core

Interface
REQ-001 SHALL have parameter RPC, default 1: SHA-256 rounds per clock; legal values 1, 2, 4, 8; any other value fails elaboration.
REQ-002 SHALL have parameter FEED_FWD, default 1: 1 adds digest_in to the final state (standard compression); 0 outputs the raw final state (midstate/debug mode).
REQ-003 SHALL have port CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: block_in and digest_in are valid.
REQ-006 SHALL have port in_ready, output, 1: core accepts a block.
REQ-007 SHALL have port block_in, input, 512: message block, W0 in bits [511:480].
REQ-008 SHALL have port digest_in, input, 256: chaining value H0..H7, H0 in bits [255:224].
REQ-009 SHALL have port abort, input, 1: synchronous cancel of any job.
REQ-010 SHALL have port out_valid, output, 1: digest_out is valid.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts digest_out.
REQ-012 SHALL have port digest_out, output, 256: result, H0 in bits [255:224].
REQ-013 SHALL have port busy, output, 1: high in LOAD, RUN or FINAL.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RUN, FINAL, DONE.
- IDLE: in_ready=1; when in_valid=1, capture block_in and digest_in, then go to LOAD.
- LOAD: load the working variables a..h from digest_in and clear the round counter.
- RUN: do RPC rounds per cycle; after 64/RPC cycles go to FINAL.
- FINAL: register digest_out, then go to DONE.
- DONE: out_valid=1; when out_ready=1, go to IDLE.
REQ-015 in_ready SHALL be 1 only in IDLE; no input is accepted in any other state, so there is no back-to-back overlap.
REQ-016 Latency: if the accept edge is t0, out_valid SHALL rise exactly 64/RPC+2 edges after t0 (66 for RPC=1, 10 for RPC=8).
REQ-017 digest_out and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-018 If out_ready is already 1 when DONE is entered, out_valid SHALL be high for exactly one cycle; in_ready SHALL rise on the next cycle.
REQ-019 Message schedule SHALL use a 16-word sliding window.
- Round t<16: W_t comes from the captured block.
- Round t>=16: W_t = s1(W_t-2)+W_t-7+s0(W_t-15)+W_t-16 mod 2^32.
- The window SHALL advance by RPC words per cycle.
REQ-020 Round constants SHALL be K[0..63] per FIPS 180-4, indexed by round_cnt*RPC+i for sub-round i.
REQ-021 All arithmetic SHALL be modulo 2^32 per word; with FEED_FWD=1, digest_out word j = H_j(in) + final word j.
REQ-022 abort=1 SHALL force IDLE on the next edge from any state and clear out_valid.
REQ-023 abort SHALL take priority over in_valid and out_ready in the same cycle; a block presented with abort=1 in IDLE SHALL NOT be accepted.
REQ-024 The round counter SHALL be width clog2(64/RPC) (minimum 1 bit) and SHALL wrap only through the LOAD clear.

Reset
REQ-025 While RST=0, every register SHALL clear asynchronously: state=IDLE, out_valid=0, busy=0, digest_out=0, counter=0, working and schedule registers=0.
REQ-026 in_ready SHALL be 1 after reset.
REQ-027 Reset asserted mid-job SHALL discard the job; no out_valid SHALL follow for that job.

Structure
REQ-028 Shared package sha256_pkg SHALL hold the K table, the IV constant (6a09e667 ... 5be0cd19), the Sigma0/Sigma1/sigma0/sigma1/Ch/Maj functions and the FSM state enum.
REQ-029 Combinational sub-module sha256_round (one round: state in, W, K, state out) SHALL be instantiated RPC times in a chain.

Verification
REQ-030 "abc" padded, digest_in=IV, RPC=1 and RPC=8 -> digest_out=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; out_valid at edge +66 and +10 respectively.
REQ-031 Empty message padded (block 80000000 then zeros), digest_in=IV -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-032 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmnomnopnopq", second block's digest_in = first result -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-033 Hold out_ready=0 for 20 cycles after out_valid -> digest_out unchanged, in_ready=0 throughout; in_ready=1 one cycle after the out_ready pulse.
REQ-034 abort asserted in RUN round 30, then "abc" submitted -> no stale out_valid; correct "abc" digest returned.
REQ-035 RST pulsed low mid-RUN -> all outputs 0 immediately, in_ready=1 after release; FEED_FWD=0 run of "abc" -> raw final state, equal to the expected digest minus IV word-wise.
